// File: rtl/expr_generator.sv
// expr_generator: producer side of the game's expression/update interface.
// Every cur_period+3 enabled cycles it emits a random, legal expression {opA, op, opB}
// plus a target lane, with a one-cycle update strobe. The emission interval shrinks
// by STEP every 8 emissions, saturating at MIN_PERIOD.
//
// Ports:
//   delay_clk     in   game clock
//   rst           in   asynchronous, active-low reset
//   i_enable      in   1 = game running; 0 = freeze counter/FSM (LFSR keeps stepping)
//   o_exp         out  [11:8] opA 1..9, [7:4] op (A=+ B=- C=* D=/), [3:0] opB 1..9
//   o_line        out  target lane 0..2
//   o_update      out  one-cycle strobe; o_exp/o_line are new in the same cycle
//   o_cur_period  out  current COUNT length in cycles
module expr_generator #(
    parameter int unsigned PERIOD     = 64,
    parameter int unsigned MIN_PERIOD = 16,
    parameter int unsigned STEP       = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        delay_clk,
    input  logic        rst,
    input  logic        i_enable,
    output logic [11:0] o_exp,
    output logic [1:0]  o_line,
    output logic        o_update,
    output logic [7:0]  o_cur_period
);

    localparam logic [1:0] S_COUNT = 2'd0;
    localparam logic [1:0] S_GEN   = 2'd1;
    localparam logic [1:0] S_FIX   = 2'd2;
    localparam logic [1:0] S_EMIT  = 2'd3;

    // An all-zero Galois LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0] SEED_FIX      = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [7:0]  PERIOD_8      = 8'(PERIOD);
    localparam logic [7:0]  MIN_8         = 8'(MIN_PERIOD);
    localparam logic [7:0]  STEP_8        = 8'(STEP);
    localparam logic [8:0]  MIN_PLUS_STEP = 9'(MIN_PERIOD + STEP);

    logic [1:0]  r_state;
    logic [7:0]  r_count;
    logic [2:0]  r_emit_cnt;
    logic [15:0] r_lfsr;
    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic [3:0]  r_op;
    logic [1:0]  r_ln;
    logic [11:0] r_exp;
    logic [1:0]  r_line;
    logic        r_update;
    logic [7:0]  r_cur_period;

    logic [15:0] w_lfsr_next;
    logic [3:0]  w_a_map;
    logic [3:0]  w_b_map;
    logic        w_swap;
    logic [3:0]  w_a_fix;
    logic [3:0]  w_b_fix;
    logic [1:0]  w_ln_fix;
    logic [7:0]  w_period_dec;

    // Raw nibble to digit 1..9: 0 -> 9, 10..15 -> 1..6.
    function automatic logic [3:0] map_digit(input logic [3:0] n);
        if (n == 4'd0) begin
            return 4'd9;
        end else if (n >= 4'd10) begin
            return n - 4'd9;
        end
        return n;
    endfunction

    always_comb begin
        w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        if (r_lfsr == 16'h0000) begin
            w_lfsr_next = 16'hACE1;
        end

        w_a_map = map_digit(r_a);
        w_b_map = map_digit(r_b);
        // Subtraction and division keep the larger operand first: no negatives, quotient >= 1.
        w_swap  = ((r_op == 4'hB) || (r_op == 4'hD)) && (w_a_map < w_b_map);
        w_a_fix = w_swap ? w_b_map : w_a_map;
        w_b_fix = w_swap ? w_a_map : w_b_map;

        // Lane 3 does not exist; rotate to the lane after the current one instead.
        w_ln_fix = r_ln;
        if (r_ln == 2'd3) begin
            w_ln_fix = (r_line == 2'd2) ? 2'd0 : r_line + 2'd1;
        end

        // Saturate rather than wrap when the step would overshoot the floor.
        if ({1'b0, r_cur_period} < MIN_PLUS_STEP) begin
            w_period_dec = MIN_8;
        end else begin
            w_period_dec = r_cur_period - STEP_8;
        end
    end

    always_ff @(posedge delay_clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_COUNT;
            r_count      <= 8'd0;
            r_emit_cnt   <= 3'd0;
            r_lfsr       <= SEED_FIX;
            r_a          <= 4'd0;
            r_b          <= 4'd0;
            r_op         <= 4'd0;
            r_ln         <= 2'd0;
            r_exp        <= 12'h000;
            r_line       <= 2'd0;
            r_update     <= 1'b0;
            r_cur_period <= PERIOD_8;
        end else begin
            r_lfsr   <= w_lfsr_next;
            r_update <= 1'b0;
            if (i_enable) begin
                case (r_state)
                    S_COUNT: begin
                        if (r_count == r_cur_period - 8'd1) begin
                            r_count <= 8'd0;
                            r_state <= S_GEN;
                        end else begin
                            r_count <= r_count + 8'd1;
                        end
                    end
                    S_GEN: begin
                        r_a     <= r_lfsr[15:12];
                        r_b     <= r_lfsr[11:8];
                        r_op    <= 4'hA + {2'b00, r_lfsr[1:0]};
                        r_ln    <= r_lfsr[5:4];
                        r_state <= S_FIX;
                    end
                    S_FIX: begin
                        r_a     <= w_a_fix;
                        r_b     <= w_b_fix;
                        r_ln    <= w_ln_fix;
                        r_state <= S_EMIT;
                    end
                    default: begin
                        r_exp      <= {r_a, r_op, r_b};
                        r_line     <= r_ln;
                        r_update   <= 1'b1;
                        r_emit_cnt <= r_emit_cnt + 3'd1;
                        if (r_emit_cnt == 3'd7) begin
                            r_cur_period <= w_period_dec;
                        end
                        r_state <= S_COUNT;
                    end
                endcase
            end
        end
    end

    assign o_exp        = r_exp;
    assign o_line       = r_line;
    assign o_update     = r_update;
    assign o_cur_period = r_cur_period;

endmodule

// File: tb/tb_expr_generator.sv
module tb_expr_generator;

    logic delay_clk = 1'b0;
    logic rst       = 1'b0;
    logic enable    = 1'b0;

    logic [2:0][11:0] exp_o;
    logic [2:0][1:0]  line_o;
    logic [2:0]       upd_o;
    logic [2:0][7:0]  per_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_emit   = 0;

    // Instance 0: defaults. Instance 1: zero seed. Instance 2: PERIOD=18 saturation case.
    expr_generator u_dut0 (
        .delay_clk(delay_clk), .rst(rst), .i_enable(enable),
        .o_exp(exp_o[0]), .o_line(line_o[0]), .o_update(upd_o[0]), .o_cur_period(per_o[0])
    );
    expr_generator #(.SEED(16'h0000)) u_dut1 (
        .delay_clk(delay_clk), .rst(rst), .i_enable(enable),
        .o_exp(exp_o[1]), .o_line(line_o[1]), .o_update(upd_o[1]), .o_cur_period(per_o[1])
    );
    expr_generator #(.PERIOD(18)) u_dut2 (
        .delay_clk(delay_clk), .rst(rst), .i_enable(enable),
        .o_exp(exp_o[2]), .o_line(line_o[2]), .o_update(upd_o[2]), .o_cur_period(per_o[2])
    );

    always #5 delay_clk = ~delay_clk;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference model state, one slot per instance.
    int          m_init[3] = '{64, 64, 18};
    int          m_k[3];
    int          m_n[3];
    logic [15:0] m_lfsr[3];
    logic [15:0] m_cap[3];
    logic [11:0] m_exp[3];
    logic [1:0]  m_line[3];
    logic        m_upd[3];
    logic [11:0] prev_exp[3];
    logic        prev_upd[3];
    logic        prev_rst = 1'b0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        if (s == 16'h0) return 16'hACE1;
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int dmap(input int n);
        return ((n + 8) % 9) + 1;
    endfunction

    // Period in force after n emissions since reset.
    function automatic int per_of(input int init, input int n);
        int p;
        p = init - 4 * (n / 8);
        return (p < 16) ? 16 : p;
    endfunction

    always @(posedge delay_clk) begin
        int p, a, b, op, ln, t;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_k[i] = 0; m_n[i] = 0; m_lfsr[i] = 16'hACE1; m_cap[i] = 16'h0;
                m_exp[i] = 12'h000; m_line[i] = 2'd0; m_upd[i] = 1'b0;
            end else begin
                p = per_of(m_init[i], m_n[i]);
                m_upd[i] = 1'b0;
                if (enable) begin
                    m_k[i]++;
                    if (m_k[i] == p + 1) m_cap[i] = m_lfsr[i];
                    if (m_k[i] == p + 3) begin
                        a  = dmap(int'(m_cap[i][15:12]));
                        b  = dmap(int'(m_cap[i][11:8]));
                        op = 10 + int'(m_cap[i][1:0]);
                        ln = int'(m_cap[i][5:4]);
                        if ((op == 11 || op == 13) && a < b) begin
                            t = a; a = b; b = t;
                        end
                        if (ln == 3) ln = (int'(m_line[i]) + 1) % 3;
                        m_exp[i]  = 12'(a * 256 + op * 16 + b);
                        m_line[i] = 2'(ln);
                        m_upd[i]  = 1'b1;
                        m_n[i]++;
                        m_k[i] = 0;
                    end
                end
                m_lfsr[i] = lfsr_step(m_lfsr[i]);
            end
            check($sformatf("update[%0d]", i), upd_o[i], m_upd[i]);
            check($sformatf("exp[%0d]", i), exp_o[i], m_exp[i]);
            check($sformatf("line[%0d]", i), line_o[i], m_line[i]);
            check($sformatf("cur_period[%0d]", i), per_o[i], per_of(m_init[i], m_n[i]));
            // Legality rules checked directly on the DUT outputs.
            if (upd_o[i]) begin
                if (i == 0) n_emit++;
                check($sformatf("legal_opA[%0d]", i),
                      (exp_o[i][11:8] >= 4'd1 && exp_o[i][11:8] <= 4'd9), 1);
                check($sformatf("legal_opB[%0d]", i),
                      (exp_o[i][3:0] >= 4'd1 && exp_o[i][3:0] <= 4'd9), 1);
                check($sformatf("legal_op[%0d]", i),
                      (exp_o[i][7:4] >= 4'hA && exp_o[i][7:4] <= 4'hD), 1);
                if (exp_o[i][7:4] == 4'hB || exp_o[i][7:4] == 4'hD)
                    check($sformatf("legal_order[%0d]", i), exp_o[i][11:8] >= exp_o[i][3:0], 1);
                check($sformatf("legal_line[%0d]", i), line_o[i] <= 2'd2, 1);
                if (prev_rst) check($sformatf("pulse_width[%0d]", i), prev_upd[i], 0);
            end else if (rst && prev_rst) begin
                check($sformatf("exp_stable[%0d]", i), exp_o[i], prev_exp[i]);
            end
            prev_exp[i] = exp_o[i];
            prev_upd[i] = upd_o[i];
        end
        prev_rst = rst;
    end

    // Edges until instance i strobes update; -1 if the budget expires.
    task automatic wait_update(input int i, input int budget, output int edges);
        bit got;
        got   = 1'b0;
        edges = 0;
        while (!got && edges < budget) begin
            @(posedge delay_clk);
            #1;
            edges++;
            if (upd_o[i]) got = 1'b1;
        end
        if (!got) edges = -1;
    endtask

    task automatic measure(input int i, input int count);
        int iv;
        for (int e = 0; e < count; e++) begin
            wait_update(i, 200, iv);
            check($sformatf("interval[%0d] #%0d", i, e), iv, per_of(m_init[i], e) + 3);
        end
    endtask

    initial begin
        int          e;
        bit          seen;
        logic [11:0] saved;

        repeat (3) @(negedge delay_clk);
        check("reset_exp", exp_o[0], 12'h000);
        check("reset_line", line_o[0], 0);
        check("reset_update", upd_o[0], 0);
        check("reset_period0", per_o[0], 64);
        check("reset_period2", per_o[2], 18);
        // Pin the model against hand-computed values.
        check("model_lfsr_step", lfsr_step(16'hACE1), 16'hE270);
        check("model_dmap0", dmap(0), 9);
        check("model_dmap12", dmap(12), 3);
        check("model_dmap7", dmap(7), 7);
        check("model_per_sat", per_of(18, 8), 16);

        rst = 1'b1; enable = 1'b1;
        wait_update(0, 200, e);
        check("first_update_latency", e, 67);
        wait_update(0, 200, e);
        check("second_interval", e, 67);

        // Reset in the middle of COUNT, 30 cycles past an emission.
        repeat (30) @(posedge delay_clk);
        @(negedge delay_clk);
        rst = 1'b0;
        #1;
        check("midreset_exp", exp_o[0], 12'h000);
        check("midreset_line", line_o[0], 0);
        check("midreset_update", upd_o[0], 0);
        check("midreset_period", per_o[0], 64);
        repeat (2) @(negedge delay_clk);
        rst = 1'b1;
        wait_update(0, 200, e);
        check("post_reset_latency", e, 67);

        // Freeze for 200 cycles at count 20.
        saved = exp_o[0];
        repeat (20) @(posedge delay_clk);
        @(negedge delay_clk);
        enable = 1'b0;
        seen   = 1'b0;
        repeat (200) begin
            @(posedge delay_clk);
            #1;
            if (upd_o != 3'b000) seen = 1'b1;
        end
        check("freeze_no_update", seen, 0);
        check("freeze_exp_hold", exp_o[0], saved);
        @(negedge delay_clk);
        enable = 1'b1;
        wait_update(0, 200, e);
        check("resume_latency", e, 47);

        // Difficulty ramp and saturation from a clean reset with enable held high.
        @(negedge delay_clk);
        rst = 1'b0;
        @(negedge delay_clk);
        rst = 1'b1;
        fork
            measure(0, 110);
            measure(2, 30);
        join

        // Randomized enable with one reset in the middle.
        for (int c = 0; c < 40000; c++) begin
            @(negedge delay_clk);
            enable = ($urandom_range(0, 7) != 0);
            rst    = (c != 20000);
        end
        @(negedge delay_clk);
        check("emissions_seen", n_emit > 1000, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
